// File: rtl/knight_cmd_pkg.sv
// rtl/knight_cmd_pkg.sv - shared types and command constants for the Knight's Tour command path
package knight_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        NEXT,
        DONE,
        ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NACK    = 2'd1,
        ERR_SND_TMO = 2'd2,
        ERR_RSP_TMO = 2'd3
    } err_code_t;

    localparam logic [7:0] POS_ACK_DEF = 8'hA5;

    // Standard commands: gyro calibration followed by the opening tour moves.
    localparam logic [15:0] CMD_CAL_GYRO = 16'h4002;
    localparam logic [15:0] CMD_MOVE_A   = 16'h5BF1;
    localparam logic [15:0] CMD_MOVE_B   = 16'h47F1;
    localparam logic [15:0] CMD_MOVE_C   = 16'h53F2;

endpackage

// File: rtl/seq_cmd_queue.sv
// rtl/seq_cmd_queue.sv - DEPTH x CMD_W command store with fill count and indexed read
module seq_cmd_queue #(
    parameter int CMD_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [CMD_W-1:0]           wr_data,
    input  logic                       clr,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [CMD_W-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;

    // Entries are not reset; only the fill count defines what is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (wr_en && !full) begin
            mem_q[IDX_W'(count_q)] <= wr_data;
            count_q                <= count_q + CNT_W'(1);
        end
    end

    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - plays queued commands to RemoteComm and checks each response
module cmd_sequencer
    import knight_cmd_pkg::*;
#(
    parameter int                CMD_W    = 16,
    parameter int                RESP_W   = 8,
    parameter int                DEPTH    = 8,
    parameter logic [RESP_W-1:0] POS_ACK  = RESP_W'(POS_ACK_DEF),
    parameter int                TMO_CLKS = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [CMD_W-1:0]           wr_cmd,
    input  logic                       clr_q,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       loop_mode,
    output logic [CMD_W-1:0]           cmd,
    output logic                       snd_cmd,
    input  logic                       cmd_snt,
    input  logic                       resp_rdy,
    input  logic [RESP_W-1:0]          resp,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       busy,
    output logic [$clog2(DEPTH)-1:0]   cur_idx,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   err_idx
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int TMO_W = $clog2(TMO_CLKS+1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CLKS);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_nxt;
    logic             err_q, err_d;
    err_code_t        err_code_q, err_code_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             load_cmd;
    logic             fail;
    err_code_t        fail_code;
    logic             more_left;
    logic             idle;
    logic [CMD_W-1:0] rd_data;

    assign idle = (state_q == IDLE);

    seq_cmd_queue #(
        .CMD_W (CMD_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && idle),
        .wr_data (wr_cmd),
        .clr     (clr_q && idle),
        .rd_idx  (cur_idx_d),
        .rd_data (rd_data),
        .count   (count),
        .full    (full)
    );

    assign more_left = (CNT_W'(cur_idx_q) + CNT_W'(1)) < count;
    assign tmo_nxt   = (tmo_q == TMO_LIM) ? tmo_q : tmo_q + TMO_W'(1);

    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        load_cmd   = 1'b0;
        fail       = 1'b0;
        fail_code  = ERR_NONE;
        if (abort && !idle) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            err_d      = 1'b0;
                            err_code_d = ERR_NONE;
                            err_idx_d  = '0;
                            cur_idx_d  = '0;
                            load_cmd   = 1'b1;
                            state_d    = SEND;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SEND: begin
                    tmo_d   = '0;
                    state_d = WAIT_SNT;
                end
                WAIT_SNT, WAIT_RESP: begin
                    // A response arriving before cmd_snt implies the send completed.
                    if (resp_rdy) begin
                        if (resp == POS_ACK) begin
                            state_d = NEXT;
                        end else begin
                            fail      = 1'b1;
                            fail_code = ERR_NACK;
                        end
                    end else if (state_q == WAIT_SNT && cmd_snt) begin
                        tmo_d   = '0;
                        state_d = WAIT_RESP;
                    end else begin
                        tmo_d = tmo_nxt;
                        if (tmo_nxt == TMO_LIM) begin
                            fail      = 1'b1;
                            fail_code = (state_q == WAIT_SNT) ? ERR_SND_TMO : ERR_RSP_TMO;
                        end
                    end
                end
                NEXT: begin
                    if (more_left) begin
                        cur_idx_d = cur_idx_q + IDX_W'(1);
                        load_cmd  = 1'b1;
                        state_d   = SEND;
                    end else if (loop_mode) begin
                        cur_idx_d = '0;
                        load_cmd  = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (fail) begin
                state_d    = ERR;
                err_d      = 1'b1;
                err_code_d = fail_code;
                err_idx_d  = cur_idx_q;
            end
        end
    end

    // cmd is captured on entry to SEND so it is stable while snd_cmd is high.
    assign cmd_d = load_cmd ? rd_data : cmd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_idx_q  <= '0;
            cmd_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            cmd_q      <= cmd_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign cmd      = cmd_q;
    assign snd_cmd  = (state_q == SEND) && !abort;
    assign busy     = !idle;
    assign done     = (state_q == DONE);
    assign cur_idx  = cur_idx_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb/tb_cmd_sequencer.sv - randomized scoreboard bench for cmd_sequencer
module tb_cmd_sequencer;
    localparam int CMD_W = 16;
    localparam int RESP_W = 8;
    localparam int DEPTH = 8;
    localparam int TMO = 50;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [7:0] ACK = 8'hA5;
    localparam int K_ACK = 0, K_NACK = 1, K_NOSNT = 2, K_NORSP = 3, K_ABORT = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic wr_en = 1'b0, clr_q = 1'b0, start = 1'b0, abort = 1'b0, loop_mode = 1'b0;
    logic [CMD_W-1:0] wr_cmd = '0;
    logic cmd_snt = 1'b0, resp_rdy = 1'b0;
    logic [RESP_W-1:0] resp = '0;
    logic [CMD_W-1:0] cmd;
    logic snd_cmd, full, busy, done, err;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] cur_idx, err_idx;
    logic [1:0] err_code;

    cmd_sequencer #(
        .CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .POS_ACK(ACK), .TMO_CLKS(TMO)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .clr_q(clr_q),
        .start(start), .abort(abort), .loop_mode(loop_mode), .cmd(cmd), .snd_cmd(snd_cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .count(count), .full(full),
        .busy(busy), .cur_idx(cur_idx), .done(done), .err(err), .err_code(err_code),
        .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; int code; int idx;} evt_t;

    int n_chk = 0, n_fail = 0, n_snd = 0, send_no = 0;
    longint cyc = 0, last_snd_cyc = 0, err_rise_cyc = 0;
    logic [CMD_W-1:0] exp_cmd_q[$];
    evt_t exp_evt_q[$];
    logic [CMD_W-1:0] mdl_q[$];
    int rsp_kind[64];
    logic [7:0] nack_val = 8'h5A;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd"}, cmd, 0);
        chk({tag, "_snd_cmd"}, snd_cmd, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_err_idx"}, err_idx, 0);
        chk({tag, "_cur_idx"}, cur_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_full"}, full, 0);
    endtask

    task automatic q_clear();
        clr_q = 1'b1;
        tick();
        clr_q = 1'b0;
        mdl_q.delete();
    endtask

    task automatic q_write(input logic [CMD_W-1:0] v);
        wr_en = 1'b1;
        wr_cmd = v;
        tick();
        wr_en = 1'b0;
        if (mdl_q.size() < DEPTH) mdl_q.push_back(v);
    endtask

    task automatic set_acks();
        foreach (rsp_kind[i]) rsp_kind[i] = K_ACK;
        send_no = 0;
    endtask

    // Reference: entries go out in order until the first bad response, else one done.
    task automatic expect_run();
        evt_t e;
        for (int i = 0; i < mdl_q.size(); i++) begin
            exp_cmd_q.push_back(mdl_q[i]);
            if (rsp_kind[i] != K_ACK) begin
                e.kind = 1;
                e.code = (rsp_kind[i] == K_NACK) ? 1 : (rsp_kind[i] == K_NOSNT) ? 2 : 3;
                e.idx = i;
                exp_evt_q.push_back(e);
                return;
            end
        end
        e.kind = 0; e.code = 0; e.idx = 0;
        exp_evt_q.push_back(e);
    endtask

    task automatic start_and_wait(input bit poke_wr);
        int t = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (poke_wr) begin
            wr_en = 1'b1;
            wr_cmd = CMD_W'($urandom);
            tick();
            wr_en = 1'b0;
        end
        while (busy && t < 3000) begin
            tick();
            t++;
        end
        chk("run_terminates", busy, 0);
        repeat (3) tick();
        chk("exp_cmds_left", exp_cmd_q.size(), 0);
        chk("exp_evts_left", exp_evt_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every send strobe and every completion event.
    initial begin
        logic err_prev, done_prev;
        evt_t e;
        err_prev = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done_prev) chk("busy_after_done", busy, 0);
            if (snd_cmd) begin
                n_snd++;
                last_snd_cyc = cyc;
                if (exp_cmd_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_snd_cmd: cmd %0h sent, no send expected", cmd);
                end else chk("cmd", cmd, exp_cmd_q.pop_front());
            end
            if (done || (err && !err_prev)) begin
                if (err && !err_prev) err_rise_cyc = cyc;
                if (exp_evt_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_event: done %0b err %0b, none expected", done, err);
                end else begin
                    e = exp_evt_q.pop_front();
                    chk("outcome_is_err", done ? 0 : 1, e.kind);
                    if (!done) begin
                        chk("err_code", err_code, e.code);
                        chk("err_idx", err_idx, e.idx);
                    end
                end
            end
            err_prev = err;
            done_prev = done;
        end
    end

    // RemoteComm stand-in with random latency; behaviour per send chosen by rsp_kind.
    initial begin
        int k, kind, d1, d2;
        forever begin
            @(posedge clk);
            #1;
            if (snd_cmd) begin
                k = send_no;
                send_no++;
                kind = (k < 64) ? rsp_kind[k] : K_ACK;
                d1 = (kind == K_NORSP) ? 0 : int'($urandom_range(0, 3));
                d2 = int'($urandom_range(0, 3));
                tick();
                if (kind != K_NOSNT) begin
                    repeat (d1) tick();
                    if (kind != K_NORSP && $urandom_range(0, 3) == 0) begin
                        resp_rdy = 1'b1;
                        resp = (kind == K_NACK) ? nack_val : ACK;
                        tick();
                        resp_rdy = 1'b0;
                    end else begin
                        cmd_snt = 1'b1;
                        tick();
                        cmd_snt = 1'b0;
                        if (kind != K_NORSP) begin
                            repeat (d2) tick();
                            resp_rdy = 1'b1;
                            resp = (kind == K_NACK) ? nack_val : ACK;
                            tick();
                            resp_rdy = 1'b0;
                        end
                    end
                    if (kind == K_ABORT) begin
                        abort = 1'b1;
                        tick();
                        abort = 1'b0;
                        chk("abort_idle_next_cycle", busy, 0);
                    end
                end
            end
        end
    end

    initial begin
        int s0, n;
        repeat (2) tick();
        rst = 1'b0;
        chk_reset_outputs("reset");

        set_acks();
        q_clear();
        q_write(knight_cmd_pkg::CMD_CAL_GYRO);
        q_write(knight_cmd_pkg::CMD_MOVE_A);
        q_write(knight_cmd_pkg::CMD_MOVE_B);
        q_write(knight_cmd_pkg::CMD_MOVE_C);
        chk("count_4", count, 4);
        s0 = n_snd;
        expect_run();
        start_and_wait(0);
        chk("single_snd_pulses", n_snd - s0, 4);
        chk("single_err", err, 0);

        set_acks();
        q_clear();
        repeat (3) q_write(CMD_W'($urandom));
        rsp_kind[1] = K_NACK;
        nack_val = 8'h5A;
        expect_run();
        start_and_wait(0);
        chk("nack_err_sticky", err, 1);

        set_acks();
        q_clear();
        repeat (2) q_write(CMD_W'($urandom));
        rsp_kind[0] = K_NOSNT;
        expect_run();
        start_and_wait(0);
        chk("snd_tmo_latency", err_rise_cyc - last_snd_cyc, TMO + 1);

        set_acks();
        rsp_kind[1] = K_NORSP;
        expect_run();
        start_and_wait(0);
        chk("rsp_tmo_latency", err_rise_cyc - last_snd_cyc, TMO + 2);

        set_acks();
        q_clear();
        q_write(16'h1111);
        q_write(16'h2222);
        rsp_kind[4] = K_ABORT;
        for (int i = 0; i < 5; i++) exp_cmd_q.push_back(mdl_q[i % 2]);
        loop_mode = 1'b1;
        start_and_wait(0);
        loop_mode = 1'b0;
        chk("loop_count_kept", count, 2);
        chk("loop_err_clear", err, 0);

        set_acks();
        q_clear();
        repeat (DEPTH + 1) q_write(CMD_W'($urandom));
        chk("fill_count", count, DEPTH);
        chk("fill_full", full, 1);
        expect_run();
        start_and_wait(1);
        chk("busy_write_ignored", count, DEPTH);
        set_acks();
        expect_run();
        start_and_wait(0);

        clr_q = 1'b1;
        wr_en = 1'b1;
        wr_cmd = 16'hBEEF;
        tick();
        clr_q = 1'b0;
        wr_en = 1'b0;
        mdl_q.delete();
        chk("clr_wins_count", count, 0);
        chk("clr_wins_full", full, 0);

        s0 = n_snd;
        expect_run();
        start_and_wait(0);
        chk("empty_start_snds", n_snd - s0, 0);

        repeat (12) begin
            set_acks();
            q_clear();
            n = int'($urandom_range(1, DEPTH));
            repeat (n) q_write(CMD_W'($urandom));
            for (int i = 0; i < n; i++) if ($urandom_range(0, 7) == 0) rsp_kind[i] = K_NACK;
            do nack_val = 8'($urandom); while (nack_val == ACK);
            expect_run();
            start_and_wait(0);
        end

        set_acks();
        q_clear();
        repeat (3) q_write(CMD_W'($urandom));
        rsp_kind[0] = K_NORSP;
        exp_cmd_q.push_back(mdl_q[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_q.delete();
        chk_reset_outputs("midrun_rst");
        cmd_snt = 1'b1;
        resp_rdy = 1'b1;
        resp = ACK;
        tick();
        cmd_snt = 1'b0;
        resp_rdy = 1'b0;
        repeat (3) tick();
        chk("late_resp_busy", busy, 0);
        chk("late_resp_err", err, 0);
        chk("late_resp_cmds_left", exp_cmd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Synthesisable, parametrised command sequencer for the Knight's Tour remote-command path. It generalises a fixed hand-written move list into a loadable queue of DEPTH commands.
- Sits in front of RemoteComm: it drives cmd/snd_cmd and consumes cmd_snt, resp_rdy and resp.
- It plays the queued commands back in order and checks every response against the positive-ack code. It reports completion, or the first failure with its index and cause.
- Optional loop mode replays the queue continuously, for soak and tour runs.

Parameters:
- CMD_W, 16, command width.
- RESP_W, 8, response width.
- DEPTH, 8, queue depth in commands (≥2).
- POS_ACK, 8'hA5, expected response for every command.
- TMO_CLKS, 1000000, clocks allowed in each wait state before a timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  push wr_cmd into the queue.
- wr_cmd  in  CMD_W  command to load.
- clr_q  in  1  empty the queue.
- start  in  1  begin playback.
- abort  in  1  stop playback.
- loop_mode  in  1  after the last entry, wrap to entry 0 instead of finishing.
- cmd  out  CMD_W  command presented to RemoteComm.
- snd_cmd  out  1  one-cycle send strobe.
- cmd_snt  in  1  RemoteComm finished transmitting.
- resp_rdy  in  1  response valid.
- resp  in  RESP_W  response byte.
- count  out  $clog2(DEPTH+1)  entries loaded.
- full  out  1  count==DEPTH.
- busy  out  1  FSM not in IDLE.
- cur_idx  out  $clog2(DEPTH)  entry in flight.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 0 none, 1 NACK, 2 send timeout, 3 response timeout.
- err_idx  out  $clog2(DEPTH)  index of the failing entry.

Behaviour:
- Reset values (rst sampled on clk):
  - FSM goes to IDLE.
  - Queue is emptied (count=0).
  - cmd=0, snd_cmd=0, done=0, err=0, err_code=0, err_idx=0, cur_idx=0, busy=0.
- Loading:
  - wr_en writes entry[count] and increments count, only when IDLE and not full.
  - wr_en is ignored when full or busy.
  - clr_q sets count=0, only when IDLE. If clr_q and wr_en are both asserted, clr_q wins.
- Start:
  - start in IDLE with count>0 clears err, err_code and err_idx, sets cur_idx=0, and enters SEND on the next cycle.
  - start in IDLE with count==0 pulses done on the next cycle and sends nothing.
  - start while busy is ignored.
- SEND (1 cycle):
  - cmd<=entry[cur_idx]; snd_cmd=1 for exactly this cycle.
  - Next state is WAIT_SNT. The timeout counter is cleared.
  - cmd holds its value until the next SEND.
- WAIT_SNT:
  - cmd_snt moves to WAIT_RESP and clears the counter.
  - resp_rdy in this state is treated as cmd_snt+resp_rdy together and evaluated as in WAIT_RESP.
  - The counter reaching TMO_CLKS moves to ERR with code 2.
- WAIT_RESP:
  - resp_rdy with resp==POS_ACK moves to NEXT.
  - resp_rdy with resp!=POS_ACK moves to ERR with code 1.
  - The counter reaching TMO_CLKS moves to ERR with code 3.
- NEXT (1 cycle):
  - If cur_idx<count-1: cur_idx++ and go to SEND.
  - Else if loop_mode (sampled here): cur_idx=0 and go to SEND.
  - Else go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- ERR (1 cycle): err=1 (sticky until the next accepted start or rst), err_idx=cur_idx, then IDLE. No done pulse.
- abort in any non-IDLE state:
  - Goes to IDLE on the next cycle and suppresses any snd_cmd that cycle.
  - err, done and the queue are unchanged.
  - abort has priority over every other transition except rst.
- Timeout counter:
  - Width $clog2(TMO_CLKS+1).
  - Saturates and never wraps.
  - Counts only in WAIT_SNT and WAIT_RESP.
- busy=1 in every state except IDLE. Throughput is at most one command per SEND→WAIT→NEXT round trip; SEND never overlaps an outstanding command.
- rst mid-playback: immediate return to reset values on that clock edge. Any later cmd_snt or resp_rdy from RemoteComm is ignored in IDLE.

Decomposition:
- Package knight_cmd_pkg holds:
  - seq_state_t enum: IDLE, SEND, WAIT_SNT, WAIT_RESP, NEXT, DONE, ERR.
  - err_code_t: ERR_NONE, ERR_NACK, ERR_SND_TMO, ERR_RSP_TMO.
  - Localparam POS_ACK_DEF=8'hA5.
  - Standard command constants (CAL_GYRO, move opcodes) shared with the benches.
- One sub-module: seq_cmd_queue, a DEPTH×CMD_W register array with count, full, write, clear and indexed read.
- The FSM and timeout counter live in cmd_sequencer.

Test Plan:
1. Single playback:
   - Stimulus: load 4 commands 16'h4002, 16'h5BF1, 16'h47F1, 16'h53F2 with the responder always returning 8'hA5; then start.
   - Response: exactly 4 snd_cmd pulses with cmd matching in that order; done pulse after the 4th ack; err=0; busy falls the cycle after done.
2. NACK:
   - Stimulus: queue of 3 commands; responder returns 8'h5A on the 2nd.
   - Response: err=1, err_code=1, err_idx=1; no 3rd snd_cmd; no done.
3. Timeouts (TMO_CLKS=50):
   - Stimulus A: cmd_snt is never asserted.
   - Response A: err_code=2 exactly 50 clocks after entering WAIT_SNT.
   - Stimulus B: cmd_snt asserted but resp_rdy never asserted.
   - Response B: err_code=3.
4. Loop and abort:
   - Stimulus: loop_mode=1 with 2 entries; run through 5 acks, then assert abort.
   - Response: cmd sequence A,B,A,B,A; IDLE the next cycle; no further snd_cmd; count still 2.
5. Queue boundaries:
   - Stimulus A: DEPTH+1 writes.
   - Response A: count=DEPTH, full=1, extra write dropped.
   - Stimulus B: wr_en while busy.
   - Response B: ignored.
   - Stimulus C: clr_q and wr_en in the same cycle.
   - Response C: count=0.
   - Stimulus D: start with count=0.
   - Response D: done pulse, zero snd_cmd.
6. Reset mid-playback:
   - Stimulus: assert rst while in WAIT_RESP; then send a late resp_rdy.
   - Response: every output at its reset value on the following cycle; the late resp_rdy has no effect.
